// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the RAM access controller: command opcodes, FSM states
// and default geometry of the attached single-port RAM.
package ram_ctrl_pkg;

  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned DW_DEF    = 3;
  localparam int unsigned DEPTH_DEF = 5;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_FILL    = 3'd4,
    S_RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/ram_access_ctrl.sv
// Valid/ready command front end for a single-port RAM with registered read
// address: read, write and block fill, one response per accepted command.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e        state;
  logic [AW-1:0] cnt;
  logic [AW:0]   fill_end;
  logic          req_err;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // Extra bit keeps addr+len from wrapping before the bound compare.
  assign fill_end = {1'b0, req_addr} + {1'b0, req_len};

  always_comb begin
    req_err = 1'b0;
    case (req_op)
      OP_READ, OP_WRITE: req_err = ({1'b0, req_addr} >= DEPTH_W);
      OP_FILL:           req_err = (fill_end > DEPTH_W);
      default:           req_err = 1'b1;
    endcase
  end

  // RAM pins are loaded one state early so the registered outputs line up
  // with the state that owns the RAM cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      ram_rw   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rsp_data <= '0;
            rsp_err  <= req_err;
            if (req_err) begin
              state <= S_RESP;
            end else begin
              ram_addr <= req_addr;
              ram_data <= req_data;
              cnt      <= req_len - AW'(1);
              case (req_op)
                OP_READ: state <= S_RD_ADDR;
                OP_WRITE: begin
                  ram_rw <= 1'b1;
                  state  <= S_WR;
                end
                default: begin
                  if (req_len == '0) begin
                    state <= S_RESP;
                  end else begin
                    ram_rw <= 1'b1;
                    state  <= S_FILL;
                  end
                end
              endcase
            end
          end
        end
        S_WR: begin
          ram_rw <= 1'b0;
          state  <= S_RESP;
        end
        S_RD_ADDR: state <= S_RD_DATA;
        S_RD_DATA: begin
          rsp_data <= ram_q;
          state    <= S_RESP;
        end
        S_FILL: begin
          if (cnt == '0) begin
            ram_rw <= 1'b0;
            state  <= S_RESP;
          end else begin
            ram_addr <= ram_addr + AW'(1);
            cnt      <= cnt - AW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: begin
          ram_rw <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: behavioural RAM plus an array-level reference
// model, directed vector table, corner sequences and random commands.
module tb_ram_access_ctrl;

  localparam int DEPTH = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = '0;
  logic [4:0] req_addr = '0;
  logic [4:0] req_len = '0;
  logic [2:0] req_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [2:0] rsp_data;
  logic       rsp_err;
  logic       ram_rw;
  logic [4:0] ram_addr;
  logic [2:0] ram_data;
  logic [2:0] ram_q;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ram_access_ctrl #(.AW(5), .DW(3), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read address.
  logic [2:0] mem [32] = '{default: '0};
  logic [4:0] areg = '0;
  always @(posedge clk) begin
    if (ram_rw) mem[ram_addr] <= ram_data;
    areg <= ram_addr;
  end
  assign ram_q = mem[areg];

  logic [7:0] wlog [$];
  always @(posedge clk) if (ram_rw) wlog.push_back({ram_addr, ram_data});

  // Reference contents of the RAM as the controller should leave them.
  logic [2:0] mm [32] = '{default: '0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, int'(req_ready), 1);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_data"},  int'(rsp_data), 0);
    chk({tag, "_rsp_err"},   int'(rsp_err), 0);
    chk({tag, "_ram_rw"},    int'(ram_rw), 0);
    chk({tag, "_ram_addr"},  int'(ram_addr), 0);
    chk({tag, "_ram_data"},  int'(ram_data), 0);
    chk({tag, "_busy"},      int'(busy), 0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] l,
                        input logic [2:0] d, input int hold,
                        output logic [2:0] rd, output logic re, output int lat);
    logic       m_err;
    logic [2:0] m_data;
    int         m_lat;
    logic [7:0] ew [$];
    m_err  = (op == 2'b11) || (op != 2'b10 && int'(a) >= DEPTH) ||
             (op == 2'b10 && int'(a) + int'(l) > DEPTH);
    m_data = 3'd0;
    m_lat  = 0;
    if (!m_err) begin
      case (op)
        2'b00: begin m_data = mm[a]; m_lat = 2; end
        2'b01: begin mm[a] = d; ew.push_back({a, d}); m_lat = 1; end
        default: begin
          for (int i = 0; i < int'(l); i++) begin
            mm[a + 5'(i)] = d;
            ew.push_back({a + 5'(i), d});
          end
          m_lat = int'(l);
        end
      endcase
    end

    @(negedge clk);
    chk("idle_ready", int'(req_ready), 1);
    wlog.delete();
    req_valid = 1'b1; req_op = op; req_addr = a; req_len = l; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_data;
    re = rsp_err;
    chk("m_latency", lat, m_lat);
    chk("m_rsp_err", int'(re), int'(m_err));
    chk("m_rsp_data", int'(rd), int'(m_data));

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 2'b01; req_addr = 5'd0; req_data = 3'd7;
      @(posedge clk); #1;
      chk("hold_rsp_valid", int'(rsp_valid), 1);
      chk("hold_rsp_data", int'(rsp_data), int'(rd));
      chk("hold_rsp_err", int'(rsp_err), int'(re));
      chk("hold_req_ready", int'(req_ready), 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", int'(rsp_valid), 0);
    chk("post_hs_busy", int'(busy), 0);

    chk("write_count", wlog.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wlog.size(); i++)
      chk("write_addr_data", int'(wlog[i]), int'(ew[i]));
  endtask

  typedef struct {
    logic [1:0] op;
    logic [4:0] addr;
    logic [4:0] len;
    logic [2:0] data;
    logic       err;
    logic [2:0] rdata;
    int         lat;
  } vec_t;

  initial begin
    vec_t       tbl [$];
    logic [2:0] rd;
    logic       re;
    int         lat;

    tbl.push_back('{2'b01, 5'd2,  5'd0, 3'd5, 1'b0, 3'd0, 1});  // write 2 <- 5
    tbl.push_back('{2'b00, 5'd2,  5'd0, 3'd0, 1'b0, 3'd5, 2});  // read 2
    tbl.push_back('{2'b10, 5'd1,  5'd3, 3'd6, 1'b0, 3'd0, 3});  // fill 1..3 <- 6
    tbl.push_back('{2'b00, 5'd1,  5'd0, 3'd0, 1'b0, 3'd6, 2});
    tbl.push_back('{2'b00, 5'd2,  5'd0, 3'd0, 1'b0, 3'd6, 2});
    tbl.push_back('{2'b00, 5'd3,  5'd0, 3'd0, 1'b0, 3'd6, 2});
    tbl.push_back('{2'b00, 5'd0,  5'd0, 3'd0, 1'b0, 3'd0, 2});
    tbl.push_back('{2'b00, 5'd5,  5'd0, 3'd0, 1'b1, 3'd0, 0});  // out of range
    tbl.push_back('{2'b01, 5'd31, 5'd0, 3'd4, 1'b1, 3'd0, 0});
    tbl.push_back('{2'b10, 5'd3,  5'd3, 3'd2, 1'b1, 3'd0, 0});
    tbl.push_back('{2'b11, 5'd0,  5'd0, 3'd1, 1'b1, 3'd0, 0});
    tbl.push_back('{2'b10, 5'd4,  5'd1, 3'd2, 1'b0, 3'd0, 1});  // ends at DEPTH-1
    tbl.push_back('{2'b00, 5'd4,  5'd0, 3'd0, 1'b0, 3'd2, 2});
    tbl.push_back('{2'b10, 5'd0,  5'd0, 3'd7, 1'b0, 3'd0, 0});  // empty fill
    tbl.push_back('{2'b00, 5'd0,  5'd0, 3'd0, 1'b0, 3'd0, 2});
    tbl.push_back('{2'b10, 5'd0,  5'd5, 3'd1, 1'b0, 3'd0, 5});  // whole array
    tbl.push_back('{2'b00, 5'd4,  5'd0, 3'd0, 1'b0, 3'd1, 2});

    repeat (2) @(negedge clk);
    chk_reset_outs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("after_reset");

    foreach (tbl[i]) begin
      do_cmd(tbl[i].op, tbl[i].addr, tbl[i].len, tbl[i].data, 0, rd, re, lat);
      chk($sformatf("vec%0d_err", i), int'(re), int'(tbl[i].err));
      chk($sformatf("vec%0d_data", i), int'(rd), int'(tbl[i].rdata));
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end

    // Backpressure: response frozen, stray requests ignored.
    do_cmd(2'b00, 5'd3, 5'd0, 3'd0, 10, rd, re, lat);
    chk("hold_read_data", int'(rd), 1);

    // Reset during the second cycle of a 4-word fill: only word 0 lands.
    @(negedge clk);
    wlog.delete();
    req_valid = 1'b1; req_op = 2'b10; req_addr = 5'd0; req_len = 5'd4; req_data = 3'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_ram_rw", int'(ram_rw), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_fill_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_fill_rsp_valid", int'(rsp_valid), 0);
    chk("rst_fill_writes", wlog.size(), 1);
    if (wlog.size() > 0) chk("rst_fill_word", int'(wlog[0]), int'({5'd0, 3'd3}));
    mm[0] = 3'd3;
    do_cmd(2'b00, 5'd0, 5'd0, 3'd0, 0, rd, re, lat);
    chk("rst_fill_rd0", int'(rd), 3);
    do_cmd(2'b00, 5'd1, 5'd0, 3'd0, 0, rd, re, lat);
    chk("rst_fill_rd1", int'(rd), 1);

    for (int n = 0; n < 60; n++) begin
      int unsigned r;
      logic [1:0]  op;
      r  = $urandom % 8;
      op = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
      do_cmd(op, 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
             3'($urandom), int'($urandom_range(0, 2)), rd, re, lat);
    end

    for (int a = 0; a < DEPTH; a++) begin
      do_cmd(2'b00, 5'(a), 5'd0, 3'd0, 0, rd, re, lat);
      chk("final_mem", int'(rd), int'(mm[a]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
